// File: rtl/apb_master_arbiter.sv
// ============================================================================
// apb_master_arbiter
// ----------------------------------------------------------------------------
// Round-robin arbiter that shares one APB master port among NUM_REQ internal
// requesters. Each accepted request runs one full APB transfer. The transfer
// goes through the IDLE -> SETUP -> ACCESS phases and waits for PREADY. The
// read data and a one-cycle completion pulse then go back to the requester
// that won the grant. Only one transfer is outstanding at a time.
//
// Optional feature (compile-time macro):
//   APB_TIMEOUT_EN  aborts an ACCESS phase after TIMEOUT_CYC cycles without
//                   PREADY and reports it through rsp_err. When the macro is
//                   not defined, ACCESS waits indefinitely and rsp_err is 0.
//
// Ports:
//   PCLK, PRESETn        clock (rising edge), synchronous active-low reset
//   req_valid/_write     per-requester request flag and direction
//   req_addr/_wdata/_strb  flattened per-requester payloads (requester i at
//                        slice i of each bus)
//   req_ready            one-hot grant pulse, combinational in the grant cycle
//   rsp_valid            one-hot completion pulse, registered
//   rsp_rdata, rsp_err   response data and abort flag, held until next completion
//   PSEL..PSTRB          registered APB master outputs
//   PRDATA, PREADY       APB slave responses
// ============================================================================
module apb_master_arbiter #(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic                          PCLK,
    input  logic                          PRESETn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_wdata,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_strb,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    output logic                          PSEL,
    output logic                          PENABLE,
    output logic                          PWRITE,
    output logic [ADDR_W-1:0]             PADDR,
    output logic [DATA_W-1:0]             PWDATA,
    output logic [DATA_W/8-1:0]           PSTRB,
    input  logic [DATA_W-1:0]             PRDATA,
    input  logic                          PREADY
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e               state_q;
    logic [IDX_W-1:0]     rr_q;
    logic [IDX_W-1:0]     gnt_q;
    logic                 psel_q;
    logic                 penable_q;
    logic                 pwrite_q;
    logic [ADDR_W-1:0]    paddr_q;
    logic [DATA_W-1:0]    pwdata_q;
    logic [STRB_W-1:0]    pstrb_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic [DATA_W-1:0]    rsp_rdata_q;

    logic                 gnt_any_d;
    logic [IDX_W-1:0]     gnt_idx_d;
    logic [IDX_W-1:0]     rr_d;
    logic [IDX_W-1:0]     cand;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [STRB_W-1:0]    sel_strb;
    logic                 sel_write;

    // Round-robin search: first pending requester at or after the pointer, wrapping.
    always_comb begin
        gnt_any_d = 1'b0;
        gnt_idx_d = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((32'(rr_q) + k) % NUM_REQ);
            if (!gnt_any_d && req_valid[cand]) begin
                gnt_any_d = 1'b1;
                gnt_idx_d = cand;
            end
        end
    end

    // Pointer moves just past the winner so it has lowest priority next time.
    assign rr_d = (gnt_idx_d == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_d + IDX_W'(1);

    // Payload mux for the winning requester.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_strb  = '0;
        sel_write = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == gnt_idx_d) begin
                sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                sel_wdata = req_wdata[i*DATA_W +: DATA_W];
                sel_strb  = req_strb[i*STRB_W +: STRB_W];
                sel_write = req_write[i];
            end
        end
    end

    // Grant acknowledge is only given from IDLE, and never while reset is held.
    assign req_ready = (PRESETn && (state_q == ST_IDLE) && gnt_any_d)
                       ? (ONE_HOT0 << gnt_idx_d) : '0;

`ifdef APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             rsp_err_q;

    assign rsp_err = rsp_err_q;
`else
    // TIMEOUT_CYC only matters when the timeout feature is compiled in.
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT_CYC);
    assign rsp_err        = 1'b0;
`endif

    // Transfer sequencer with registered APB and response outputs.
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            gnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
`ifdef APB_TIMEOUT_EN
            wait_cnt_q  <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (gnt_any_d) begin
                        gnt_q    <= gnt_idx_d;
                        rr_q     <= rr_d;
                        paddr_q  <= sel_addr;
                        pwrite_q <= sel_write;
                        pwdata_q <= sel_wdata;
                        pstrb_q  <= sel_write ? sel_strb : '0;
                        psel_q   <= 1'b1;
                        state_q  <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    penable_q  <= 1'b1;
                    state_q    <= ST_ACCESS;
`ifdef APB_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        rsp_valid_q <= ONE_HOT0 << gnt_q;
                        rsp_rdata_q <= pwrite_q ? '0 : PRDATA;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= ST_IDLE;
`ifdef APB_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        // Abort: report error with zero data.
                        rsp_valid_q <= ONE_HOT0 << gnt_q;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else begin
                        wait_cnt_q  <= wait_cnt_q + CNT_W'(1);
`endif
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PSTRB     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: a transaction-level reference model is checked
// every cycle, together with directed scenarios that use hand-computed values.
module tb_apb_master_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 16;

    logic            PCLK = 1'b0;
    logic            PRESETn = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N*SW-1:0] req_strb = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            PSEL, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [SW-1:0]   PSTRB;
    logic [DW-1:0]   PRDATA = '0;
    logic            PREADY = 1'b0;

    apb_master_arbiter #(
        .NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT_CYC(TO)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_strb(req_strb),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    initial forever #5 PCLK = ~PCLK;

    int n_total = 0;
    int n_bad   = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (one transfer at a time) ----------------
    bit              m_busy  = 1'b0;   // a granted transfer is on the bus
    int unsigned     m_age   = 0;      // cycles since grant: 1 = setup, >=2 = access
    int unsigned     m_rr    = 0;
    int              m_gnt   = 0;
    logic [AW-1:0]   m_addr  = '0;
    logic            m_write = 1'b0;
    logic [DW-1:0]   m_wdata = '0;
    logic [SW-1:0]   m_strb  = '0;
    logic [N-1:0]    m_rsp   = '0;
    logic [DW-1:0]   m_rdata = '0;
    logic            m_err   = 1'b0;

    // Lowest pending requester when the vector is viewed rotated to start at ptr.
    function automatic int first_from(input logic [N-1:0] v, input int unsigned ptr);
        logic [2*N-1:0] dbl;
        dbl = {v, v} >> ptr;
        for (int p = 0; p < int'(N); p++)
            if (dbl[p]) return int'((ptr + p) % N);
        return -1;
    endfunction

    always @(negedge PCLK) begin : cmp_proc
        int           g;
        logic [N-1:0] exp_rdy;
        g       = first_from(req_valid, m_rr);
        exp_rdy = '0;
        if (PRESETn && !m_busy && g >= 0) exp_rdy[g] = 1'b1;
        if (chk_en) begin
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("PSEL",      64'(PSEL),      64'(m_busy));
            chk("PENABLE",   64'(PENABLE),   64'(m_busy && m_age >= 2));
            chk("PWRITE",    64'(PWRITE),    64'(m_write));
            chk("PADDR",     64'(PADDR),     64'(m_addr));
            chk("PWDATA",    64'(PWDATA),    64'(m_wdata));
            chk("PSTRB",     64'(PSTRB),     64'(m_strb));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_rsp));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(m_rdata));
            chk("rsp_err",   64'(rsp_err),   64'(m_err));
        end
        if (!PRESETn) begin
            m_busy = 1'b0; m_age = 0; m_rr = 0; m_gnt = 0;
            m_addr = '0; m_write = 1'b0; m_wdata = '0; m_strb = '0;
            m_rsp = '0; m_rdata = '0; m_err = 1'b0;
        end else begin
            m_rsp = '0;
            if (!m_busy) begin
                if (g >= 0) begin
                    m_gnt   = g;
                    m_rr    = (g + 1) % N;
                    m_addr  = req_addr[g*AW +: AW];
                    m_write = req_write[g];
                    m_wdata = req_wdata[g*DW +: DW];
                    m_strb  = req_write[g] ? req_strb[g*SW +: SW] : '0;
                    m_busy  = 1'b1;
                    m_age   = 1;
                end
            end else if (m_age >= 2 && PREADY) begin
                m_rsp[m_gnt] = 1'b1;
                m_rdata      = m_write ? '0 : PRDATA;
                m_err        = 1'b0;
                m_busy       = 1'b0;
`ifdef APB_TIMEOUT_EN
            end else if (m_age >= 2 && (m_age - 1) == TO) begin
                m_rsp[m_gnt] = 1'b1;
                m_rdata      = '0;
                m_err        = 1'b1;
                m_busy       = 1'b0;
`endif
            end else begin
                m_age++;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic at_neg();
        @(negedge PCLK);
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [SW-1:0] s);
        req_write[i]         = w;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req_strb[i*SW +: SW] = s;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        PREADY    = 1'b1;
        repeat (n) tick();
    endtask

    initial begin : stim
        int pen;
        bit got;
        int gi[4];
        int gc[4];
        int ng;
        logic [N-1:0]  rdy_last;
        logic [AW-1:0] s_addr;
        logic [DW-1:0] s_wdata;
        logic [SW-1:0] s_strb;
        logic          s_write;

        // reset
        repeat (2) @(posedge PCLK);
        #1;
        PRESETn = 1'b1;
        chk_en  = 1'b1;
        at_neg();
        chk("rst_psel",    64'(PSEL), 64'd0);
        chk("rst_penable", 64'(PENABLE), 64'd0);
        chk("rst_paddr",   64'(PADDR), 64'd0);
        chk("rst_rsp",     64'(rsp_valid), 64'd0);

        // T1: write, zero wait states
        tick();
        set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        req_valid = 3'b001;
        PREADY    = 1'b1;
        at_neg();
        chk("t1_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        at_neg();
        chk("t1_setup_psel",    64'(PSEL), 64'd1);
        chk("t1_setup_penable", 64'(PENABLE), 64'd0);
        chk("t1_paddr",         64'(PADDR), 64'h10);
        chk("t1_pwdata",        64'(PWDATA), 64'hDEADBEEF);
        chk("t1_pstrb",         64'(PSTRB), 64'hF);
        chk("t1_pwrite",        64'(PWRITE), 64'd1);
        tick();
        at_neg();
        chk("t1_access_penable", 64'(PENABLE), 64'd1);
        tick();
        at_neg();
        chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        chk("t1_rsp_err",   64'(rsp_err), 64'd0);
        chk("t1_psel_done", 64'(PSEL), 64'd0);

        // T2: read with 3 wait states
        tick();
        set_req(1, 1'b0, 32'h40, 32'h0BAD_F00D, 4'hF);
        req_valid = 3'b010;
        PREADY    = 1'b0;
        PRDATA    = 32'h12345678;
        at_neg();
        chk("t2_ready", 64'(req_ready), 64'h2);
        pen = 0;
        got = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) req_valid = '0;
            if (c == 5) PREADY = 1'b1;
            at_neg();
            if (PENABLE) pen++;
            if (PSEL) chk("t2_pstrb_zero", 64'(PSTRB), 64'd0);
            if (rsp_valid != '0 && !got) begin
                got = 1'b1;
                chk("t2_rsp_valid", 64'(rsp_valid), 64'h2);
                chk("t2_rsp_rdata", 64'(rsp_rdata), 64'h12345678);
                chk("t2_rsp_cycle", 64'(c), 64'd6);
            end
        end
        chk("t2_penable_cycles", 64'(pen), 64'd4);
        chk("t2_rsp_seen", 64'(got), 64'd1);

        // T3: fairness, req0 and req1 continuously valid
        tick();
        set_req(0, 1'b0, 32'h100, 32'h1, 4'h1);
        set_req(1, 1'b1, 32'h200, 32'h2, 4'h3);
        req_valid = 3'b011;
        PREADY    = 1'b1;
        ng = 0;
        for (int c = 0; c < 12; c++) begin
            at_neg();
            if (req_ready != '0) begin
                if (ng < 4) begin
                    gc[ng] = c;
                    for (int b = 0; b < int'(N); b++) if (req_ready[b]) gi[ng] = b;
                end
                ng++;
            end
            tick();
        end
        req_valid = '0;
        chk("t3_grant_count", 64'(ng), 64'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < ng) begin
                chk("t3_grant_idx",   64'(gi[k]), 64'(k % 2));
                chk("t3_grant_cycle", 64'(gc[k]), 64'(3 * k));
            end
        end

        // T4: reset during ACCESS; pointer would otherwise favour req1
        idle(3);
        set_req(0, 1'b0, 32'h300, 32'h3, 4'h7);
        req_valid = 3'b001;
        PREADY    = 1'b0;
        at_neg();
        chk("t4_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = 3'b011;
        tick();
        at_neg();
        chk("t4_in_access", 64'(PENABLE), 64'd1);
        tick();
        PRESETn = 1'b0;
        tick();
        PRESETn = 1'b1;
        at_neg();
        chk("t4_psel_cleared",    64'(PSEL), 64'd0);
        chk("t4_penable_cleared", 64'(PENABLE), 64'd0);
        chk("t4_paddr_cleared",   64'(PADDR), 64'd0);
        chk("t4_no_rsp",          64'(rsp_valid), 64'd0);
        chk("t4_first_grant",     64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        PREADY    = 1'b1;
        idle(4);

        // T5: PREADY held low
        set_req(1, 1'b0, 32'h500, 32'h5, 4'hF);
        req_valid = 3'b010;
        PREADY    = 1'b0;
        PRDATA    = 32'hAAAA5555;
        at_neg();
        chk("t5_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        pen = 0;
        got = 1'b0;
`ifdef APB_TIMEOUT_EN
        for (int c = 0; c < 40; c++) begin
            at_neg();
            if (PENABLE) pen++;
            if (rsp_valid != '0 && !got) begin
                got = 1'b1;
                chk("t5_abort_valid", 64'(rsp_valid), 64'h2);
                chk("t5_abort_err",   64'(rsp_err), 64'd1);
                chk("t5_abort_rdata", 64'(rsp_rdata), 64'd0);
            end
            tick();
        end
        chk("t5_access_cycles", 64'(pen), 64'(TO));
        chk("t5_abort_seen",    64'(got), 64'd1);
`else
        for (int c = 0; c < 1000; c++) begin
            at_neg();
            if (rsp_valid != '0) got = 1'b1;
            tick();
        end
        at_neg();
        chk("t5_still_access", 64'(PENABLE), 64'd1);
        chk("t5_no_rsp",       64'(got), 64'd0);
        tick();
`endif
        idle(4);

        // T6: random traffic, random PREADY, occasional reset
        rdy_last = '0;
        s_addr = '0; s_wdata = '0; s_strb = '0; s_write = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < int'(N); i++) begin
                if (req_valid[i] && rdy_last[i]) begin
                    req_valid[i] = 1'b0;
                end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom,
                            SW'($urandom_range(0, 15)));
                    req_valid[i] = 1'b1;
                end
            end
            PREADY  = ($urandom_range(0, 3) != 0);
            PRDATA  = $urandom;
            PRESETn = ($urandom_range(0, 299) != 0);
            at_neg();
            rdy_last = req_ready;
            if (PSEL && !PENABLE) begin
                s_addr = PADDR; s_wdata = PWDATA; s_strb = PSTRB; s_write = PWRITE;
            end else if (PSEL && PENABLE) begin
                chk("t6_paddr_stable",  64'(PADDR),  64'(s_addr));
                chk("t6_pwdata_stable", 64'(PWDATA), 64'(s_wdata));
                chk("t6_pstrb_stable",  64'(PSTRB),  64'(s_strb));
                chk("t6_pwrite_stable", 64'(PWRITE), 64'(s_write));
            end
        end
        PRESETn = 1'b1;
        idle(6);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
